// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the processor-side RAM access controller:
//   - state_t         : controller state encoding
//   - MEM_READ/WRITE  : levels of the RAM Read_H_Write_L line
//   - DEFAULT_TIMEOUT : default per-phase handshake timeout in cycles
// -----------------------------------------------------------------------------
package mem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// Interfaces of the RAM access controller.
//   mem_req_if : control unit <-> controller (single load/store request and
//                one-cycle response). master = control unit, slave = controller.
//     Req_Valid/Req_Write/Req_Address/Req_WData  : request from control unit
//     Req_Ready/Resp_Valid/Resp_RData/Resp_Error : status/response to it
//   mem_bus_if : controller <-> RAM (four-phase strobe/MFC handshake).
//                master = controller, slave = RAM.
//     Mem_Address/Mem_Read_H_Write_L/Mem_Data_Out/Mem_Strobe : to RAM
//     Mem_Data_In/Mem_MFC                                    : from RAM
// -----------------------------------------------------------------------------
interface mem_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Req_Valid;
  logic              Req_Write;
  logic [ADDR_W-1:0] Req_Address;
  logic [DATA_W-1:0] Req_WData;
  logic              Req_Ready;
  logic              Resp_Valid;
  logic [DATA_W-1:0] Resp_RData;
  logic              Resp_Error;

  modport master (
    output Req_Valid, Req_Write, Req_Address, Req_WData,
    input  Req_Ready, Resp_Valid, Resp_RData, Resp_Error
  );

  modport slave (
    input  Req_Valid, Req_Write, Req_Address, Req_WData,
    output Req_Ready, Resp_Valid, Resp_RData, Resp_Error
  );
endinterface

interface mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] Mem_Address;
  logic              Mem_Read_H_Write_L;
  logic [DATA_W-1:0] Mem_Data_Out;
  logic              Mem_Strobe;
  logic [DATA_W-1:0] Mem_Data_In;
  logic              Mem_MFC;

  modport master (
    output Mem_Address, Mem_Read_H_Write_L, Mem_Data_Out, Mem_Strobe,
    input  Mem_Data_In, Mem_MFC
  );

  modport slave (
    input  Mem_Address, Mem_Read_H_Write_L, Mem_Data_Out, Mem_Strobe,
    output Mem_Data_In, Mem_MFC
  );
endinterface

// File: rtl/mem_access_ctrl_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
// Saturating cycle counter used to bound each handshake phase.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (count -> 0)
//   i_clear    : synchronous clear, wins over i_enable
//   i_enable   : count up by one, holding at TIMEOUT (never wraps)
//   o_terminal : count == TIMEOUT-1, decoded from the count register only
// -----------------------------------------------------------------------------
module mem_timeout_counter
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == CNT_TERM);

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Processor-side initiator for the RAM strobe/MFC four-phase handshake. Takes
// one load/store at a time from the control unit, drives the RAM, waits for
// MFC (bounded by TIMEOUT cycles per phase) and returns a one-cycle response.
//   Clock   : system clock, rising edge
//   Reset_L : asynchronous active-low reset; aborts any access in flight
//   req     : mem_req_if.slave  (request in, Req_Ready/response out)
//   mem     : mem_bus_if.master (address/direction/data/strobe out, data/MFC in)
// Every output is a register; none depends combinationally on an input.
// TIMEOUT must be at least 2.
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic       Clock,
  input logic       Reset_L,
  mem_req_if.slave  req,
  mem_bus_if.master mem
);

  state_t            r_state;
  logic              r_write;
  logic              r_error;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_error;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rhwl;
  logic [DATA_W-1:0] r_mem_dout;
  logic              r_mem_strobe;

  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_cnt_term;

  // The counter restarts on acceptance and again when ACCESS ends, so each
  // handshake phase gets its own full TIMEOUT budget.
  always_comb begin
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE:    w_cnt_clear = req.Req_Valid;
      ST_ACCESS: begin
        w_cnt_en    = 1'b1;
        w_cnt_clear = mem.Mem_MFC | w_cnt_term;
      end
      ST_RELEASE: w_cnt_en = 1'b1;
      default:    ;
    endcase
  end

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk      (Clock),
    .i_rst_n    (Reset_L),
    .i_clear    (w_cnt_clear),
    .i_enable   (w_cnt_en),
    .o_terminal (w_cnt_term)
  );

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_error      <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_rhwl   <= MEM_READ;
      r_mem_dout   <= '0;
      r_mem_strobe <= 1'b0;
    end else begin
      // Response flags are single-cycle pulses unless re-armed below.
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req.Req_Valid) begin
            r_write      <= req.Req_Write;
            r_error      <= 1'b0;
            r_req_ready  <= 1'b0;
            r_mem_addr   <= req.Req_Address;
            r_mem_rhwl   <= req.Req_Write ? MEM_WRITE : MEM_READ;
            r_mem_dout   <= req.Req_Write ? req.Req_WData : '0;
            r_mem_strobe <= 1'b1;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // MFC is checked first so a completion on the last allowed cycle
          // still counts as success.
          if (mem.Mem_MFC || w_cnt_term) begin
            if (mem.Mem_MFC) begin
              r_error <= 1'b0;
              if (!r_write) r_resp_rdata <= mem.Mem_Data_In;
            end else begin
              r_error <= 1'b1;
              if (!r_write) r_resp_rdata <= '0;
            end
            r_mem_strobe <= 1'b0;
            r_mem_rhwl   <= MEM_READ;
            r_mem_dout   <= '0;
            r_state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Wait for the RAM to drop MFC; give up after TIMEOUT cycles.
          if (!mem.Mem_MFC) begin
            r_resp_valid <= 1'b1;
            r_resp_error <= r_error;
            r_state      <= ST_DONE;
          end else if (w_cnt_term) begin
            r_error      <= 1'b1;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req.Req_Ready          = r_req_ready;
  assign req.Resp_Valid         = r_resp_valid;
  assign req.Resp_RData         = r_resp_rdata;
  assign req.Resp_Error         = r_resp_error;
  assign mem.Mem_Address        = r_mem_addr;
  assign mem.Mem_Read_H_Write_L = r_mem_rhwl;
  assign mem.Mem_Data_Out       = r_mem_dout;
  assign mem.Mem_Strobe         = r_mem_strobe;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed transactions against mem_access_ctrl. Each transaction describes the
// RAM's MFC line as a window [rise, fall) of cycles counted from the accepting
// edge. A transaction-level model derives from that window when the access
// phase ends, when the release phase ends and whether it timed out, and from
// that the expected value of every output in every cycle; a negedge process
// compares the DUT against it. Literal checks pin the model on the key cases.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_req_if #(.ADDR_W(AW), .DATA_W(DW)) req_if ();
  mem_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  mem_access_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (T)
  ) dut (
    .Clock   (clk),
    .Reset_L (rst_n),
    .req     (req_if),
    .mem     (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit chk_en = 1'b0;
  int cur_k  = 0;

  logic          exp_ready, exp_valid, exp_error, exp_strobe, exp_rhwl;
  logic [DW-1:0] exp_rdata, exp_dout;
  logic [AW-1:0] exp_addr;

  int            obs_strobe, obs_release, obs_valid_n, obs_valid_cycle;
  logic          obs_err;
  logic [DW-1:0] obs_rdata;
  int            txn_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cur_k, act, exp);
    end
  endtask

  function automatic bit mfc_at(input int k, input int rise, input int fall);
    return (k >= rise) && (k < fall);
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("Req_Ready",  32'(req_if.Req_Ready),           32'(exp_ready));
      chk("Resp_Valid", 32'(req_if.Resp_Valid),          32'(exp_valid));
      chk("Resp_Error", 32'(req_if.Resp_Error),          32'(exp_error));
      chk("Resp_RData", req_if.Resp_RData,               exp_rdata);
      chk("Mem_Strobe", 32'(bus_if.Mem_Strobe),          32'(exp_strobe));
      chk("Mem_RHWL",   32'(bus_if.Mem_Read_H_Write_L),  32'(exp_rhwl));
      chk("Mem_DOut",   bus_if.Mem_Data_Out,             exp_dout);
      chk("Mem_Addr",   bus_if.Mem_Address,              exp_addr);
      if (bus_if.Mem_Strobe) obs_strobe++;
      if (!bus_if.Mem_Strobe && !req_if.Req_Ready && !req_if.Resp_Valid) obs_release++;
      if (req_if.Resp_Valid) begin
        obs_valid_n++;
        obs_valid_cycle = cur_k;
        obs_err         = req_if.Resp_Error;
        obs_rdata       = req_if.Resp_RData;
      end
    end
  end

  task automatic set_idle_exp();
    exp_ready  = 1'b1;
    exp_valid  = 1'b0;
    exp_error  = 1'b0;
    exp_strobe = 1'b0;
    exp_rhwl   = 1'b1;
    exp_dout   = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_if.Req_Valid   = 1'b0;
      bus_if.Mem_MFC     = 1'b0;
      bus_if.Mem_Data_In = '0;
      set_idle_exp();
      cur_k = -1;
      @(posedge clk); #1;
    end
  endtask

  // Called in the cycle before the accepting edge (cycle 0); returns in the
  // first IDLE cycle after the response (cycle R+2).
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int rise, input int fall,
                         input bit hold_valid);
    int a_end, r_end;
    bit acc_to, rel_to;
    a_end  = T;
    acc_to = 1'b1;
    for (int k = 1; k <= T; k++)
      if (acc_to && mfc_at(k, rise, fall)) begin a_end = k; acc_to = 1'b0; end
    r_end  = a_end + T;
    rel_to = 1'b1;
    for (int k = a_end + 1; k <= a_end + T; k++)
      if (rel_to && !mfc_at(k, rise, fall)) begin r_end = k; rel_to = 1'b0; end

    obs_strobe = 0; obs_release = 0; obs_valid_n = 0; obs_valid_cycle = -1;
    obs_err = 1'b0; obs_rdata = '0;

    cur_k = 0;
    req_if.Req_Valid   = 1'b1;
    req_if.Req_Write   = wr;
    req_if.Req_Address = addr;
    req_if.Req_WData   = wdata;
    bus_if.Mem_MFC     = mfc_at(0, rise, fall);
    bus_if.Mem_Data_In = bus_if.Mem_MFC ? rdata : 32'hBAD0_0000;
    set_idle_exp();

    for (int k = 1; k <= r_end + 1; k++) begin
      @(posedge clk); #1;
      cur_k = k;
      // Fields change while busy; the DUT must ignore them.
      req_if.Req_Valid   = hold_valid;
      req_if.Req_Write   = ~wr;
      req_if.Req_Address = ~addr;
      req_if.Req_WData   = ~wdata;
      bus_if.Mem_MFC     = mfc_at(k, rise, fall);
      bus_if.Mem_Data_In = bus_if.Mem_MFC ? rdata : (32'hBAD0_0000 | 32'(k));
      exp_ready  = 1'b0;
      exp_valid  = (k == r_end + 1);
      exp_error  = (k == r_end + 1) && (acc_to || rel_to);
      exp_strobe = (k <= a_end);
      exp_rhwl   = (k <= a_end) ? ~wr : 1'b1;
      exp_dout   = ((k <= a_end) && wr) ? wdata : '0;
      exp_addr   = addr;
      if (!wr && (k == a_end + 1)) exp_rdata = acc_to ? '0 : rdata;
    end
    @(posedge clk); #1;
    cur_k = r_end + 2;
    req_if.Req_Valid = hold_valid;
    bus_if.Mem_MFC   = mfc_at(r_end + 2, rise, fall);
    set_idle_exp();
    txn_no++;
    $display("txn %0d: %s addr=%h mfc=[%0d,%0d) resp_cycle=%0d err=%0d rdata=%h",
             txn_no, wr ? "write" : "read ", addr, rise, fall, r_end + 1,
             acc_to || rel_to, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_if.Req_Valid   = 1'b0;
    req_if.Req_Write   = 1'b0;
    req_if.Req_Address = '0;
    req_if.Req_WData   = '0;
    bus_if.Mem_MFC     = 1'b0;
    bus_if.Mem_Data_In = '0;
    set_idle_exp();
    exp_rdata = '0;
    exp_addr  = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_Req_Ready",  32'(req_if.Req_Ready),          32'd1);
    chk("rst_Resp_Valid", 32'(req_if.Resp_Valid),         32'd0);
    chk("rst_Mem_Strobe", 32'(bus_if.Mem_Strobe),         32'd0);
    chk("rst_Mem_RHWL",   32'(bus_if.Mem_Read_H_Write_L), 32'd1);
    chk("rst_Resp_RData", req_if.Resp_RData,              32'd0);
    chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Minimum-latency read
    run_txn(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2, 1'b0);
    chk("t1_resp_cycle", 32'(obs_valid_cycle), 32'd3);
    chk("t1_rdata",      obs_rdata,            32'hDEADBEEF);
    chk("t1_error",      32'(obs_err),         32'd0);
    idle(1);

    // Write, MFC after 4 strobe cycles; RAM data must not reach Resp_RData
    run_txn(1'b1, 32'h10, 32'h12345678, 32'h5555AAAA, 5, 6, 1'b0);
    chk("t2_strobe_cycles", 32'(obs_strobe),      32'd5);
    chk("t2_resp_cycle",    32'(obs_valid_cycle), 32'd7);
    chk("t2_rdata_kept",    obs_rdata,            32'hDEADBEEF);
    idle(1);

    // Read, MFC never arrives
    run_txn(1'b0, 32'h200, 32'h0, 32'h0BADF00D, 1000, 1000, 1'b0);
    chk("t3_strobe_cycles", 32'(obs_strobe),      32'd15);
    chk("t3_resp_cycle",    32'(obs_valid_cycle), 32'd17);
    chk("t3_error",         32'(obs_err),         32'd1);
    chk("t3_rdata",         obs_rdata,            32'd0);
    idle(1);

    // Read completes but MFC sticks high
    run_txn(1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 2, 1000, 1'b0);
    chk("t4_release_cycles", 32'(obs_release),     32'd15);
    chk("t4_resp_cycle",     32'(obs_valid_cycle), 32'd18);
    chk("t4_error",          32'(obs_err),         32'd1);
    chk("t4_rdata",          obs_rdata,            32'hCAFEF00D);
    idle(1);

    // MFC on the last allowed access cycle is still a success
    run_txn(1'b0, 32'h304, 32'h0, 32'h13579BDF, 15, 16, 1'b0);
    chk("t5_strobe_cycles", 32'(obs_strobe), 32'd15);
    chk("t5_error",         32'(obs_err),    32'd0);
    chk("t5_rdata",         obs_rdata,       32'h13579BDF);
    idle(1);

    // Req_Valid held high across three back-to-back accesses
    run_txn(1'b0, 32'h20, 32'h0, 32'h11111111, 1, 3, 1'b1);
    chk("t6_resp_cycle",     32'(obs_valid_cycle), 32'd4);
    chk("t6_release_cycles", 32'(obs_release),     32'd2);
    run_txn(1'b1, 32'h24, 32'hA5A5A5A5, 32'h0, 2, 3, 1'b1);
    chk("t7_rdata_kept", obs_rdata,   32'h11111111);
    chk("t7_one_resp",   32'(obs_valid_n), 32'd1);
    // MFC already high before acceptance (stale)
    run_txn(1'b0, 32'h28, 32'h0, 32'h22222222, 0, 3, 1'b0);
    chk("t8_resp_cycle", 32'(obs_valid_cycle), 32'd4);
    chk("t8_rdata",      obs_rdata,            32'h22222222);
    idle(2);

    // Reset pulsed in the middle of a write access
    chk_en = 1'b0;
    cur_k  = 0;
    req_if.Req_Valid   = 1'b1;
    req_if.Req_Write   = 1'b1;
    req_if.Req_Address = 32'h40;
    req_if.Req_WData   = 32'h99;
    bus_if.Mem_MFC     = 1'b0;
    @(posedge clk); #1;
    req_if.Req_Valid = 1'b0;
    @(posedge clk); #1;
    cur_k = 2;
    chk("rstmid_pre_strobe", 32'(bus_if.Mem_Strobe),         32'd1);
    chk("rstmid_pre_rhwl",   32'(bus_if.Mem_Read_H_Write_L), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_strobe", 32'(bus_if.Mem_Strobe),         32'd0);
    chk("rstmid_rhwl",   32'(bus_if.Mem_Read_H_Write_L), 32'd1);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    exp_rdata = '0;
    exp_addr  = '0;
    set_idle_exp();
    obs_valid_n = 0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    idle(5);
    chk("rstmid_no_resp", 32'(obs_valid_n), 32'd0);

    // Normal operation after the aborted access
    run_txn(1'b0, 32'h44, 32'h0, 32'h77777777, 3, 4, 1'b0);
    chk("t9_resp_cycle", 32'(obs_valid_cycle), 32'd5);
    chk("t9_rdata",      obs_rdata,            32'h77777777);
    idle(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
